wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Wishbone N-master to 1-slave arbiter; the converging counterpart of the 1-master/N-slave switch and address decoder.
- Sits in front of the switch master port so the CPU, DMA and VGA fetch masters share one bus.
- Round-robin grant, held for the whole cycle (cyc) of the owner.
- Bus watchdog: completes a hung access with a forced ack so no master stalls forever.

Parameters:
- NM, 3, number of masters (2..4)
- TIMEOUT, 255, cycles of stb without ack before forced completion; 0 disables the watchdog
- TO_W, 8, watchdog counter width; must satisfy TIMEOUT < 2**TO_W

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- m_dat_i  in  NM*16  master write data; master k in bits [16k+15:16k]
- m_dat_o  out  16  read data, broadcast to all masters
- m_adr_i  in  NM*20  master word address [20:1]; master k in bits [20k+19:20k]
- m_sel_i  in  NM*2  byte selects
- m_we_i  in  NM  write enables
- m_cyc_i  in  NM  cycle requests
- m_stb_i  in  NM  strobes
- m_ack_o  out  NM  per-master ack
- s_dat_i  in  16  slave read data
- s_dat_o  out  16  slave write data
- s_adr_o  out  20  slave address [20:1]
- s_sel_o  out  2  slave byte selects
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_ack_i  in  1  slave ack
- gnt_o  out  NM  one-hot current grant, registered
- timeout_o  out  1  one-cycle pulse on forced completion

Behaviour:
- States: IDLE, BUSY.
- Pointer `last` holds the index of the most recently granted master.
- Reset (async, wb_rst_ni=0):
  - state=IDLE, gnt_o=0, last=NM-1 (master 0 wins first), watchdog count=0, timeout_o=0.
  - All slave control outputs are 0; m_ack_o=0.
- Arbitration edge: any rising edge where state=IDLE, or state=BUSY with m_cyc_i[owner]=0.
  - If any m_cyc_i is set: grant the first requester searching last+1, last+2, ... modulo NM; set gnt_o one-hot, last=winner, state=BUSY.
  - Otherwise: gnt_o=0, state=IDLE.
- Latency:
  - Grant takes effect the cycle after cyc is sampled, i.e. one cycle of arbitration latency.
  - Handover between masters needs no idle cycle: the owner dropping cyc and a new grant happen on the same edge.
- Routing (combinational from gnt_o):
  - s_adr_o/s_sel_o/s_dat_o/s_we_o take the owner's fields.
  - s_cyc_o = BUSY & m_cyc_i[owner].
  - s_stb_o = s_cyc_o & m_stb_i[owner] & ~force.
  - With no grant: all slave controls 0, s_adr_o/s_dat_o/s_sel_o 0.
- Acks:
  - m_ack_o[owner] = s_ack_i | force; all other bits 0.
  - m_dat_o = force ? 16'hFFFF : s_dat_i.
  - A stray s_ack_i with no grant is dropped.
- Watchdog (TIMEOUT>0):
  - Count clears when s_stb_o=0 or s_ack_i=1; otherwise increments each cycle.
  - force = (count == TIMEOUT) & ~s_ack_i.
  - In a force cycle: count clears, timeout_o=1 next cycle (registered pulse).
  - Count saturates; it never wraps.
- Simultaneous events:
  - If s_ack_i and the timeout coincide, the real ack wins: force=0, no timeout pulse.
  - If the owner drops cyc mid-transfer, its grant is released at that edge; a late slave ack is not forwarded.
- Masters hold stb until ack (standard Wishbone classic). Multi-beat cycles (cyc held across several stb/ack) keep the grant.

Test Plan:
- Reset, then m_cyc_i=3'b111 held with single-beat cycles, each released after its ack -> gnt_o sequence 001, 010, 100, 001; slave stb first asserted 1 cycle after cyc.
- Master 1 holds cyc for 3 beats while master 0 requests -> gnt_o stays 010 until master 1 drops cyc, then 001 on the same edge, no idle cycle.
- Master 2 read at address 20'hA0000 with s_dat_i=16'h1234 and ack in cycle 2 -> s_adr_o=20'hA0000, m_ack_o=3'b100 for 1 cycle, m_dat_o=16'h1234, m_ack_o[1:0]=0.
- TIMEOUT=4, slave never acks -> after 4 stb cycles m_ack_o[owner]=1 with m_dat_o=16'hFFFF, s_stb_o=0 that cycle, timeout_o pulses 1 cycle later, next master is granted.
- TIMEOUT=4, s_ack_i arrives exactly at count=4 -> real data delivered, timeout_o stays 0.
- wb_rst_ni pulled low mid-transfer -> gnt_o, s_cyc_o, s_stb_o, m_ack_o go 0 immediately (async); after release master 0 has priority.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - Wishbone NM-master to 1-slave round-robin arbiter with bus watchdog
//
// Purpose: lets several Wishbone classic masters share one slave port. The
// grant rotates round-robin and is held for the owner's whole cyc. A watchdog
// completes a hung strobe with a forced ack, so no master can stall forever.
//
// Ports:
//   wb_clk_i, wb_rst_ni    clock, asynchronous active-low reset
//   m_dat_i/m_adr_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i
//                          packed master request fields; master k occupies slice k
//   m_dat_o, m_ack_o       read data (broadcast) and per-master ack
//   s_dat_o/s_adr_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o
//                          owner's request routed to the slave
//   s_dat_i, s_ack_i       slave response
//   gnt_o                  one-hot registered grant
//   timeout_o              one-cycle pulse after a forced completion
module wb_arbiter #(
  parameter int NM      = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [NM*16-1:0] m_dat_i,
  output logic [15:0]      m_dat_o,
  input  logic [NM*20-1:0] m_adr_i,
  input  logic [NM*2-1:0]  m_sel_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  output logic [NM-1:0]    m_ack_o,
  input  logic [15:0]      s_dat_i,
  output logic [15:0]      s_dat_o,
  output logic [19:0]      s_adr_o,
  output logic [1:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_ack_i,
  output logic [NM-1:0]    gnt_o,
  output logic             timeout_o
);

  localparam int IW = $clog2(NM);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   winner;
  logic [TO_W-1:0] count;
  logic            any_req;
  logic            owner_cyc;
  logic            owner_stb;
  logic            raw_stb;
  logic            force_ack;
  logic            arb_edge;

  // Owner's request fields, selected by the one-hot grant (AND-OR mux).
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gnt_o[k]) begin
        owner_cyc = m_cyc_i[k];
        owner_stb = m_stb_i[k];
        s_adr_o   = m_adr_i[20*k +: 20];
        s_dat_o   = m_dat_i[16*k +: 16];
        s_sel_o   = m_sel_i[2*k +: 2];
        s_we_o    = m_we_i[k];
      end
    end
  end

  // Round-robin search starting just after the most recently granted master.
  always_comb begin : pick
    logic found;
    int   idx;
    any_req = |m_cyc_i;
    winner  = last;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NM; i++) begin
      idx = (int'(last) + i) % NM;
      if (!found && m_cyc_i[idx]) begin
        winner = idx[IW-1:0];
        found  = 1'b1;
      end
    end
  end

  assign s_cyc_o  = (state == BUSY) && owner_cyc;
  assign raw_stb  = s_cyc_o && owner_stb;
  // A real ack arriving in the deadline cycle beats the watchdog.
  assign force_ack = (TIMEOUT != 0) && raw_stb && (count == TO_W'(TIMEOUT)) && !s_ack_i;
  assign s_stb_o  = raw_stb && !force_ack;
  // Acks only reach a master that still holds cyc; stray or late acks vanish.
  assign m_ack_o  = s_cyc_o ? (gnt_o & {NM{s_ack_i || force_ack}}) : '0;
  assign m_dat_o  = force_ack ? 16'hFFFF : s_dat_i;

  // Re-arbitrate when idle or when the owner has let go of cyc.
  assign arb_edge = (state == IDLE) || !owner_cyc;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      gnt_o     <= '0;
      last      <= IW'(NM - 1);
      count     <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= force_ack;

      // Counts consecutive unanswered strobe cycles, saturating at the deadline.
      if (!raw_stb || s_ack_i || force_ack) begin
        count <= '0;
      end else if ((TIMEOUT != 0) && (count != TO_W'(TIMEOUT))) begin
        count <= count + TO_W'(1);
      end

      if (arb_edge) begin
        if (any_req) begin
          state <= BUSY;
          gnt_o <= NM'(1) << winner;
          last  <= winner;
        end else begin
          state <= IDLE;
          gnt_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized scoreboard bench for wb_arbiter
module tb_wb_arbiter;

  localparam int NM = 3;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM*16-1:0] m_dat_i;
  logic [15:0]      m_dat_o;
  logic [NM*20-1:0] m_adr_i;
  logic [NM*2-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_ack_o;
  logic [15:0]      s_dat_i;
  logic [15:0]      s_dat_o;
  logic [19:0]      s_adr_o;
  logic [1:0]       s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_ack_i;
  logic [NM-1:0]    gnt_o;
  logic             timeout_o;

  wb_arbiter #(.NM(NM), .TIMEOUT(TO), .TO_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .m_dat_i  (m_dat_i),
    .m_dat_o  (m_dat_o),
    .m_adr_i  (m_adr_i),
    .m_sel_i  (m_sel_i),
    .m_we_i   (m_we_i),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_ack_o  (m_ack_o),
    .s_dat_i  (s_dat_i),
    .s_dat_o  (s_dat_o),
    .s_adr_o  (s_adr_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (s_ack_i),
    .gnt_o    (gnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // kind: 0 first beat of a round, 1 first beat after a handover, 2 later beat
  typedef struct {
    int          m;
    logic [19:0] adr;
    logic [15:0] wdat;
    logic [1:0]  sel;
    logic        we;
    logic [15:0] dat;
    logic        to;
    int          kind;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc_n = 0;
  int   cyc_rise = 0;
  int   last_ack = 0;
  int   round_start = 0;
  logic mon_en = 1'b0;
  logic to_exp = 1'b0;
  logic prev_scyc = 1'b0;

  logic [19:0] b_adr[NM][4];
  logic [15:0] b_wd[NM][4];
  logic [15:0] b_rd[NM][4];
  logic [1:0]  b_sel[NM][4];
  logic        b_we[NM][4];
  int          b_lat[NM][4];
  int          nb[NM];
  int          bi[NM];
  logic        act[NM];
  int          mdl_last = NM - 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  // Monitor: pops the scoreboard whenever any master is acked.
  always begin
    @(negedge clk);
    #2;
    cyc_n++;
    if (mon_en) begin
      if (s_cyc_o && !prev_scyc) cyc_rise = cyc_n;
      chk("timeout_pulse", 32'(timeout_o), 32'(to_exp));
      to_exp = 1'b0;
      if (m_ack_o != '0) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_ack: got %b expected 000", m_ack_o);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_owner", 32'(m_ack_o), 32'(1) << mon_e.m);
          chk("gnt", 32'(gnt_o), 32'(1) << mon_e.m);
          chk("rdata", 32'(m_dat_o), 32'(mon_e.dat));
          if (mon_e.to) begin
            chk("stb_forced_low", 32'(s_stb_o), 32'd0);
          end else begin
            chk("s_stb", 32'(s_stb_o), 32'd1);
            chk("s_adr", 32'(s_adr_o), 32'(mon_e.adr));
            chk("s_dat", 32'(s_dat_o), 32'(mon_e.wdat));
            chk("s_sel", 32'(s_sel_o), 32'(mon_e.sel));
            chk("s_we", 32'(s_we_o), 32'(mon_e.we));
          end
          if (mon_e.kind == 0) chk("grant_latency", 32'(cyc_rise), 32'(round_start + 1));
          if (mon_e.kind == 1) chk("handover_gap", 32'(cyc_rise), 32'(last_ack + 2));
          to_exp   = mon_e.to;
          last_ack = cyc_n;
        end
      end
    end
    prev_scyc = s_cyc_o;
  end

  task automatic drive_masters();
    for (int m = 0; m < NM; m++) begin
      m_cyc_i[m]          = act[m];
      m_stb_i[m]          = act[m];
      m_adr_i[20*m +: 20] = act[m] ? b_adr[m][bi[m]] : 20'h0;
      m_dat_i[16*m +: 16] = act[m] ? b_wd[m][bi[m]] : 16'h0;
      m_sel_i[2*m +: 2]   = act[m] ? b_sel[m][bi[m]] : 2'b00;
      m_we_i[m]           = act[m] ? b_we[m][bi[m]] : 1'b0;
    end
  endtask

  task automatic run_round();
    logic [NM-1:0] req;
    logic [NM-1:0] ack_seen;
    int            order[$];
    int            scnt;
    int            own;
    int            guard;
    logic          any;
    exp_t          e;
    req = NM'($urandom_range(1, 2**NM - 1));
    for (int m = 0; m < NM; m++) begin
      act[m] = req[m];
      bi[m]  = 0;
      nb[m]  = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) begin
        b_adr[m][b] = 20'($urandom);
        b_wd[m][b]  = 16'($urandom);
        b_rd[m][b]  = 16'($urandom);
        b_sel[m][b] = 2'($urandom);
        b_we[m][b]  = 1'($urandom);
        b_lat[m][b] = $urandom_range(1, TO + 3);
      end
    end
    // Reference: all requesters hold cyc, so they are served in cyclic order after mdl_last.
    for (int i = 1; i <= NM; i++) begin
      int c;
      c = (mdl_last + i) % NM;
      if (req[c]) order.push_back(c);
    end
    mdl_last = order[order.size() - 1];
    foreach (order[j]) begin
      for (int b = 0; b < nb[order[j]]; b++) begin
        e.m    = order[j];
        e.adr  = b_adr[e.m][b];
        e.wdat = b_wd[e.m][b];
        e.sel  = b_sel[e.m][b];
        e.we   = b_we[e.m][b];
        // Slave answering on the (TO+1)th strobe cycle still beats the watchdog.
        e.to   = (b_lat[e.m][b] > TO + 1);
        e.dat  = e.to ? 16'hFFFF : b_rd[e.m][b];
        e.kind = (b != 0) ? 2 : ((j == 0) ? 0 : 1);
        sb.push_back(e);
      end
    end
    round_start = cyc_n + 1;
    ack_seen = '0;
    scnt = 0;
    guard = 0;
    forever begin
      for (int m = 0; m < NM; m++) begin
        if (act[m] && ack_seen[m]) begin
          bi[m]++;
          if (bi[m] == nb[m]) act[m] = 1'b0;
        end
      end
      guard++;
      if (guard > 200) begin
        n_chk++;
        $display("FAIL round_bound: got %0d cycles expected under 200", guard);
        for (int m = 0; m < NM; m++) act[m] = 1'b0;
        sb.delete();
      end
      drive_masters();
      any = 1'b0;
      for (int m = 0; m < NM; m++) any |= act[m];
      if (!any) break;
      s_ack_i = 1'b0;
      s_dat_i = 16'($urandom);
      #1;
      own = -1;
      for (int m = 0; m < NM; m++) if (gnt_o[m]) own = m;
      if (s_cyc_o && own >= 0 && act[own]) begin
        scnt++;
        if (scnt == b_lat[own][bi[own]]) begin
          s_ack_i = 1'b1;
          s_dat_i = b_rd[own][bi[own]];
        end
      end
      #1;
      ack_seen = m_ack_o;
      if (|m_ack_o) scnt = 0;
      @(negedge clk);
    end
    // Two idle cycles with stray slave acks that must not reach any master.
    for (int k = 0; k < 2; k++) begin
      s_ack_i = 1'($urandom);
      s_dat_i = 16'($urandom);
      @(negedge clk);
    end
    s_ack_i = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_dat_i = '0;
    m_adr_i = '0;
    m_sel_i = '0;
    m_we_i  = '0;
    m_cyc_i = '0;
    m_stb_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    for (int m = 0; m < NM; m++) begin
      act[m] = 1'b0;
      bi[m]  = 0;
    end
    #3;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_scyc", 32'(s_cyc_o), 32'd0);
    chk("rst_sstb", 32'(s_stb_o), 32'd0);
    chk("rst_ack", 32'(m_ack_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 40; r++) run_round();

    mon_en = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Master 2 read at 0xA0000, then reset mid-transfer.
    m_cyc_i = 3'b100;
    m_stb_i = 3'b100;
    m_adr_i = '0;
    m_adr_i[59:40] = 20'hA0000;
    m_we_i  = '0;
    @(negedge clk);
    #1;
    chk("dir_stb", 32'(s_stb_o), 32'd1);
    chk("dir_adr", 32'(s_adr_o), 32'hA0000);
    s_ack_i = 1'b1;
    s_dat_i = 16'h1234;
    #1;
    chk("dir_ack", 32'(m_ack_o), 32'b100);
    chk("dir_rdata", 32'(m_dat_o), 32'h1234);
    @(negedge clk);
    s_ack_i = 1'b0;
    m_adr_i[59:40] = 20'hA0001;
    #3;
    rst_n   = 1'b0;
    s_ack_i = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt_o), 32'd0);
    chk("async_scyc", 32'(s_cyc_o), 32'd0);
    chk("async_sstb", 32'(s_stb_o), 32'd0);
    chk("async_ack", 32'(m_ack_o), 32'd0);
    @(negedge clk);
    m_cyc_i = '0;
    m_stb_i = '0;
    s_ack_i = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    m_cyc_i = 3'b111;
    m_stb_i = 3'b111;
    @(negedge clk);
    #1;
    chk("post_rst_gnt", 32'(gnt_o), 32'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
